write_pointer_ctrl: RTL and testbench

- Write-side pointer and full-flag controller for the asynchronous FIFO, running entirely in the write clock domain.
- Counterpart of the read-side pointer logic.
- Accepts write requests and generates the memory write enable and address.
- Publishes a Gray-coded write pointer for the read domain, and synchronises the read domain's Gray pointer to produce full, almost-full, fill count and a sticky overflow flag.

---
 rtl/write_pointer_ctrl_if.sv | 42 ++++
 rtl/write_pointer_ctrl.sv | 100 ++++++++++
 tb/tb_write_pointer_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/write_pointer_ctrl_if.sv
// Write-side FIFO bus: producer handshake, cross-domain pointers and status flags.
interface write_pointer_ctrl_if #(
    parameter int unsigned ADDR_W = 3
);
    localparam int unsigned PTR_W = ADDR_W + 1;

    logic              w_en;
    logic [PTR_W-1:0]  r_ptr_gray;
    logic              mem_we;
    logic [ADDR_W-1:0] w_addr;
    logic [PTR_W-1:0]  w_ptr_gray;
    logic              full;
    logic              almost_full;
    logic [PTR_W-1:0]  wr_count;
    logic              overflow;

    // Producer / read-domain side: drives requests and the foreign pointer.
    modport master (
        output w_en,
        output r_ptr_gray,
        input  mem_we,
        input  w_addr,
        input  w_ptr_gray,
        input  full,
        input  almost_full,
        input  wr_count,
        input  overflow
    );

    // Controller side.
    modport slave (
        input  w_en,
        input  r_ptr_gray,
        output mem_we,
        output w_addr,
        output w_ptr_gray,
        output full,
        output almost_full,
        output wr_count,
        output overflow
    );
endinterface

// File: rtl/write_pointer_ctrl.sv
// Write-domain pointer, full/almost-full and fill-count logic for an async FIFO.
module write_pointer_ctrl #(
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_THRESH   = 6
) (
    input  logic                 w_clk,
    input  logic                 rst,
    write_pointer_ctrl_if.slave  bus
);
    localparam int unsigned PTR_W = ADDR_W + 1;
    // Top two bits inverted marks a write pointer exactly one lap ahead.
    localparam logic [PTR_W-1:0] FULL_MASK = {2'b11, {(PTR_W-2){1'b0}}};
    localparam logic [PTR_W-1:0] AF_LEVEL  = PTR_W'(AF_THRESH);

    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b = '0;
        for (int i = 0; i < int'(PTR_W); i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [PTR_W-1:0]                  w_bin_q,  w_bin_d;
    logic [PTR_W-1:0]                  w_gray_q, w_gray_d;
    logic                              overflow_q, overflow_d;
    logic [SYNC_STAGES-1:0][PTR_W-1:0] sync_q;

    logic [PTR_W-1:0] rq_gray;
    logic [PTR_W-1:0] rq_bin;
    logic [PTR_W-1:0] count;
    logic             full;
    logic             mem_we;

    // Read-pointer view after the synchroniser chain.
    always_comb begin
        rq_gray = sync_q[SYNC_STAGES-1];
        rq_bin  = gray2bin(rq_gray);
    end

    // Status derived from registered pointers only, so it is glitch-free per cycle.
    always_comb begin
        full   = (w_gray_q == (rq_gray ^ FULL_MASK));
        count  = w_bin_q - rq_bin;
        mem_we = bus.w_en & ~full;
    end

    // Pointer advance on accepted writes; overflow latches on a rejected write.
    always_comb begin
        w_bin_d    = w_bin_q;
        w_gray_d   = w_gray_q;
        overflow_d = overflow_q;
        if (mem_we) begin
            w_bin_d  = w_bin_q + PTR_W'(1);
            w_gray_d = bin2gray(w_bin_d);
        end
        if (bus.w_en && full) begin
            overflow_d = 1'b1;
        end
    end

    // Write pointer and sticky overflow registers.
    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            w_bin_q    <= '0;
            w_gray_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            w_bin_q    <= w_bin_d;
            w_gray_q   <= w_gray_d;
            overflow_q <= overflow_d;
        end
    end

    // Multi-flop synchroniser for the read-domain Gray pointer.
    always_ff @(posedge w_clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.r_ptr_gray};
        end
    end

    // Drive the bus outputs.
    always_comb begin
        bus.mem_we      = mem_we;
        bus.w_addr      = w_bin_q[ADDR_W-1:0];
        bus.w_ptr_gray  = w_gray_q;
        bus.full        = full;
        bus.almost_full = (count >= AF_LEVEL);
        bus.wr_count    = count;
        bus.overflow    = overflow_q;
    end

endmodule

// File: tb/tb_write_pointer_ctrl.sv
// Self-checking bench for write_pointer_ctrl against a counter-based FIFO model.
module tb_write_pointer_ctrl;
    localparam int ADDR_W = 3;
    localparam int SYNC   = 2;
    localparam int AF     = 6;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int MODP   = 2 * DEPTH;

    logic w_clk;
    logic rst;
    logic clk_run;

    write_pointer_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    write_pointer_ctrl #(
        .ADDR_W(ADDR_W),
        .SYNC_STAGES(SYNC),
        .AF_THRESH(AF)
    ) dut (
        .w_clk(w_clk),
        .rst(rst),
        .bus(bus)
    );

    int errors;
    int checks;

    // Model: total accepted writes, read pointer issued by the reader,
    // the read pointer as the write side has seen it (SYNC edges late), sticky overflow.
    int wcnt;
    int r_bin;
    int hist [SYNC];
    bit ovf;

    always #5 if (clk_run) w_clk = ~w_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int gray(input int b);
        int m;
        m = b % MODP;
        return m ^ (m >> 1);
    endfunction

    function automatic int exp_count();
        return ((wcnt - hist[SYNC-1]) % MODP + MODP) % MODP;
    endfunction

    task automatic model_reset();
        wcnt  = 0;
        r_bin = 0;
        ovf   = 0;
        for (int i = 0; i < SYNC; i++) hist[i] = 0;
    endtask

    // One cycle: drive on the falling edge, check, then advance the model on the rising edge.
    task automatic step(input bit we, input int rb);
        int  cnt;
        bit  f;
        @(negedge w_clk);
        bus.w_en       = we;
        bus.r_ptr_gray = 4'(gray(rb));
        r_bin          = rb;
        #1;
        cnt = exp_count();
        f   = (cnt == DEPTH);
        check("mem_we",      32'(bus.mem_we),      32'(we && !f));
        check("w_addr",      32'(bus.w_addr),      32'(wcnt % DEPTH));
        check("w_ptr_gray",  32'(bus.w_ptr_gray),  32'(gray(wcnt)));
        check("full",        32'(bus.full),        32'(f));
        check("wr_count",    32'(bus.wr_count),    32'(cnt));
        check("almost_full", 32'(bus.almost_full), 32'(cnt >= AF));
        check("overflow",    32'(bus.overflow),    32'(ovf));
        @(posedge w_clk);
        if (we && !f) wcnt++;
        if (we && f)  ovf = 1;
        for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = rb;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gray"},  32'(bus.w_ptr_gray),  32'd0);
        check({tag, "_addr"},  32'(bus.w_addr),      32'd0);
        check({tag, "_count"}, 32'(bus.wr_count),    32'd0);
        check({tag, "_full"},  32'(bus.full),        32'd0);
        check({tag, "_af"},    32'(bus.almost_full), 32'd0);
        check({tag, "_ovf"},   32'(bus.overflow),    32'd0);
        check({tag, "_we"},    32'(bus.mem_we),      32'd0);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        w_clk   = 0;
        clk_run = 0;
        rst     = 0;
        bus.w_en       = 0;
        bus.r_ptr_gray = '0;
        model_reset();

        // Reset with the clock idle.
        #1 rst = 1;
        #2 check_zero("rst_idle");
        clk_run = 1;
        @(negedge w_clk);
        rst = 0;
        repeat (4) step(0, 0);
        #1 check_zero("rst_hold");

        // Fill from empty with the reader parked at 0.
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_addr", 32'(bus.w_addr), 32'(i));
            step(1, 0);
            #1;
            if (i == 4) check("af_below", 32'(bus.almost_full), 32'd0);
            if (i == 5) check("af_at_6",  32'(bus.almost_full), 32'd1);
        end
        check("fill_full",  32'(bus.full),       32'd1);
        check("fill_count", 32'(bus.wr_count),   32'd8);
        check("fill_gray",  32'(bus.w_ptr_gray), 32'b1100);

        // Write while full is rejected and latches overflow.
        step(1, 0);
        #1;
        check("ovf_set",  32'(bus.overflow),   32'd1);
        check("ovf_gray", 32'(bus.w_ptr_gray), 32'b1100);

        // Reader frees one slot: full persists until the synchroniser catches up.
        step(0, 1);
        #1 check("sync_full_e1", 32'(bus.full), 32'd1);
        step(0, 1);
        #1;
        check("sync_full_e2", 32'(bus.full),     32'd0);
        check("sync_count",   32'(bus.wr_count), 32'd7);
        check("ovf_sticky",   32'(bus.overflow), 32'd1);
        step(1, 1);
        #1 check("refill_full", 32'(bus.full), 32'd1);

        // Randomised writes and read advances, wrapping the pointers many times.
        for (int c = 0; c < 600; c++) begin
            int rb;
            rb = r_bin;
            if (rb < wcnt && ($urandom_range(0, 99) < 45)) rb++;
            step(($urandom_range(0, 99) < 60), rb);
        end

        // Clean restart, fill to 5, then an asynchronous reset pulse between edges.
        @(negedge w_clk);
        rst = 1;
        #1 model_reset();
        bus.w_en = 0;
        bus.r_ptr_gray = '0;
        @(negedge w_clk);
        rst = 0;
        repeat (5) step(1, 0);
        #1 check("mid_count5", 32'(bus.wr_count), 32'd5);
        @(negedge w_clk);
        bus.w_en = 0;
        #1 rst = 1;
        #1 check_zero("mid_rst");
        model_reset();
        #1 rst = 0;
        check("mid_next_addr", 32'(bus.w_addr), 32'd0);
        step(1, 0);
        #1 check("mid_after_addr", 32'(bus.w_addr), 32'd1);
        repeat (3) step(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
